// File: rtl/svo_fb_stream.sv
// Framebuffer scan-out source: linear pixel reads over a request/response memory
// port, buffered in a credit-managed FIFO, emitted as AXI-Stream with SOF on tuser.
module svo_fb_stream #(
  parameter int H_RES      = 800,
  parameter int V_RES      = 600,
  parameter int BPP        = 24,
  parameter int ADDR_W     = 20,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [BPP-1:0]    mem_rsp_data,
  output logic              out_axis_tvalid,
  input  logic              out_axis_tready,
  output logic [BPP-1:0]    out_axis_tdata,
  output logic              out_axis_tuser,
  output logic              frame_done,
  output logic              underflow
);

  localparam int PIX_W = $clog2(H_RES * V_RES + 1);
  localparam int X_W   = $clog2(H_RES + 1);
  localparam int Y_W   = $clog2(V_RES + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PIX_W-1:0] LAST_PIX   = PIX_W'(H_RES * V_RES - 1);
  localparam logic [X_W-1:0]   X_LAST     = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0]   Y_LAST     = Y_W'(V_RES - 1);
  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [ADDR_W-1:0] cur_addr_r;
  logic [PIX_W-1:0]  fetch_cnt_r;
  logic [CNT_W-1:0]  credit_r;
  logic [BPP-1:0]    fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  fifo_cnt_r;
  logic [X_W-1:0]    x_r;
  logic [Y_W-1:0]    y_r;
  logic              frame_done_r;
  logic              underflow_r;
  logic              req_fire_s;
  logic              out_fire_s;
  logic              last_req_s;
  logic              load_base_s;
  logic              at_origin_s;

  // Credit covers FIFO occupancy plus in-flight reads, so a response always has a slot.
  assign mem_req_valid   = (state_r == FETCH) && (credit_r < CREDIT_MAX);
  assign mem_req_addr    = cur_addr_r;
  assign out_axis_tvalid = (fifo_cnt_r != CNT_W'(0));
  assign out_axis_tdata  = out_axis_tvalid ? fifo_mem_r[rd_ptr_r] : {BPP{1'b0}};
  assign at_origin_s     = (x_r == X_W'(0)) && (y_r == Y_W'(0));
  assign out_axis_tuser  = out_axis_tvalid && at_origin_s;
  assign frame_done      = frame_done_r;
  assign underflow       = underflow_r;

  assign req_fire_s = mem_req_valid && mem_req_ready;
  assign out_fire_s = out_axis_tvalid && out_axis_tready;
  assign last_req_s = (fetch_cnt_r == LAST_PIX);

  // Fetch FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Fetch FSM next state; enable is only looked at on frame boundaries.
  always_comb begin
    state_s     = state_r;
    load_base_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable) begin
          state_s     = FETCH;
          load_base_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        if (req_fire_s && last_req_s) begin
          if (enable) begin
            state_s     = FETCH;
            load_base_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = FETCH;
        end
      end
      default: begin
        state_s     = IDLE;
        load_base_s = 1'b0;
      end
    endcase
  end

  // Fetch address and pixel counter; the frame base is relatched at each frame start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_addr_r  <= {ADDR_W{1'b0}};
      fetch_cnt_r <= {PIX_W{1'b0}};
    end else if (load_base_s) begin
      cur_addr_r  <= base_addr;
      fetch_cnt_r <= {PIX_W{1'b0}};
    end else if (req_fire_s) begin
      cur_addr_r  <= cur_addr_r + ADDR_W'(1);
      fetch_cnt_r <= fetch_cnt_r + PIX_W'(1);
    end
  end

  // Credit counter: up on request transfer, down on output handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit_r <= {CNT_W{1'b0}};
    end else begin
      case ({req_fire_s, out_fire_s})
        2'b10:   credit_r <= credit_r + CNT_W'(1);
        2'b01:   credit_r <= credit_r - CNT_W'(1);
        default: credit_r <= credit_r;
      endcase
    end
  end

  // Pixel storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (mem_rsp_valid) begin
      fifo_mem_r[wr_ptr_r] <= mem_rsp_data;
    end
  end

  // FIFO pointers and occupancy; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      fifo_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (mem_rsp_valid) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (out_fire_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({mem_rsp_valid, out_fire_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_W'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_W'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  // Output raster position, advanced per accepted pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_r <= {X_W{1'b0}};
      y_r <= {Y_W{1'b0}};
    end else if (out_fire_s) begin
      if (x_r == X_LAST) begin
        x_r <= {X_W{1'b0}};
        y_r <= (y_r == Y_LAST) ? {Y_W{1'b0}} : y_r + Y_W'(1);
      end else begin
        x_r <= x_r + X_W'(1);
      end
    end
  end

  // End-of-frame pulse and sticky underflow; stalling before a frame's first pixel is legal.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_done_r <= 1'b0;
      underflow_r  <= 1'b0;
    end else begin
      frame_done_r <= out_fire_s && (x_r == X_LAST) && (y_r == Y_LAST);
      if (out_axis_tready && !out_axis_tvalid && !at_origin_s) begin
        underflow_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_svo_fb_stream.sv
// Randomized bench for svo_fb_stream: memory responder with variable latency and a
// frame-level reference model of the expected request and pixel streams.
module tb_svo_fb_stream;

  localparam int H     = 4;
  localparam int V     = 2;
  localparam int HV    = H * V;
  localparam int DEPTH = 16;
  localparam int AW    = 20;
  localparam int BW    = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable;
  logic [AW-1:0] base_addr;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic          mem_rsp_valid;
  logic [BW-1:0] mem_rsp_data;
  logic          out_axis_tvalid;
  logic          out_axis_tready;
  logic [BW-1:0] out_axis_tdata;
  logic          out_axis_tuser;
  logic          frame_done;
  logic          underflow;

  svo_fb_stream #(
    .H_RES(H), .V_RES(V), .BPP(BW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .base_addr(base_addr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .out_axis_tvalid(out_axis_tvalid),
    .out_axis_tready(out_axis_tready), .out_axis_tdata(out_axis_tdata),
    .out_axis_tuser(out_axis_tuser), .frame_done(frame_done),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  int vec_cnt;
  int err_cnt;
  int cyc;

  // reference model state
  bit            fetching;
  logic [AW-1:0] fbase;
  int            fidx;
  int            credit_m;
  int            fifo_m;
  int            oidx;
  bit            fd_exp;
  bit            uf_exp;
  logic [BW:0]   exp_q[$];
  logic [AW-1:0] mq_addr[$];
  int            mq_due[$];
  int            last_due;

  // stimulus knobs
  int ready_pct;
  int tready_pct;
  int lat_lo;
  int lat_hi;
  int tready_block;

  function automatic logic [BW-1:0] pix(input logic [AW-1:0] a);
    return {a, 4'h9} ^ 24'h5A3C96;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_model();
    fetching = 1'b0;
    fidx     = 0;
    credit_m = 0;
    fifo_m   = 0;
    oidx     = 0;
    fd_exp   = 1'b0;
    uf_exp   = 1'b0;
    exp_q.delete();
    mq_addr.delete();
    mq_due.delete();
    last_due = cyc;
  endtask

  // Asserts reset, checks the outputs clear at once, releases at a falling edge.
  task automatic do_reset();
    reset           = 1'b1;
    enable          = 1'b0;
    mem_req_ready   = 1'b0;
    mem_rsp_valid   = 1'b0;
    mem_rsp_data    = '0;
    out_axis_tready = 1'b0;
    #1;
    check_val("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check_val("rst_req_addr", 32'(mem_req_addr), 32'd0);
    check_val("rst_tvalid", 32'(out_axis_tvalid), 32'd0);
    check_val("rst_tdata", 32'(out_axis_tdata), 32'd0);
    check_val("rst_tuser", 32'(out_axis_tuser), 32'd0);
    check_val("rst_frame_done", 32'(frame_done), 32'd0);
    check_val("rst_underflow", 32'(underflow), 32'd0);
    repeat (2) @(negedge clk);
    clear_model();
    reset = 1'b0;
  endtask

  // One cycle: check outputs, drive inputs, predict the coming rising edge.
  task automatic step();
    bit            rf;
    bit            of;
    logic [AW-1:0] ea;
    logic [AW-1:0] ra;
    logic [BW:0]   ep;
    int            due;
    check_val("tvalid", 32'(out_axis_tvalid), 32'(fifo_m > 0));
    check_val("req_valid", 32'(mem_req_valid), 32'(fetching && credit_m < DEPTH));
    check_val("frame_done", 32'(frame_done), 32'(fd_exp));
    check_val("underflow", 32'(underflow), 32'(uf_exp));

    mem_req_ready   = (int'($urandom_range(99)) < ready_pct);
    out_axis_tready = (tready_block > 0) ? 1'b0 : (int'($urandom_range(99)) < tready_pct);
    if (tready_block > 0) tready_block--;

    rf = mem_req_valid && mem_req_ready;
    of = out_axis_tvalid && out_axis_tready;

    if (out_axis_tready && fifo_m == 0 && oidx != 0) uf_exp = 1'b1;
    fd_exp = of && (oidx == HV - 1);
    if (of) begin
      check_val("pending", 32'(exp_q.size() != 0), 32'd1);
      ep = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      check_val("tdata", 32'(out_axis_tdata), 32'(ep[BW-1:0]));
      check_val("tuser", 32'(out_axis_tuser), 32'(ep[BW]));
      oidx = (oidx + 1) % HV;
      credit_m--;
      fifo_m--;
    end

    if (rf) begin
      ea = fbase + AW'(fidx);
      check_val("req_addr", 32'(mem_req_addr), 32'(ea));
      exp_q.push_back({fidx == 0, pix(ea)});
      due = cyc + 1 + int'($urandom_range(lat_hi, lat_lo));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq_addr.push_back(mem_req_addr);
      mq_due.push_back(due);
      credit_m++;
      fidx++;
      if (fidx == HV) begin
        if (enable) begin
          fbase = base_addr;
          fidx  = 0;
        end else begin
          fetching = 1'b0;
        end
      end
    end else if (!fetching && enable) begin
      fetching = 1'b1;
      fbase    = base_addr;
      fidx     = 0;
    end

    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    if (mq_due.size() != 0 && mq_due[0] <= cyc + 1) begin
      ra = mq_addr.pop_front();
      void'(mq_due.pop_front());
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = pix(ra);
      fifo_m++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int n;
    logic [AW-1:0] rb;
    vec_cnt = 0; err_cnt = 0; cyc = 0;
    enable = 1'b0; base_addr = '0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0; out_axis_tready = 1'b0;
    ready_pct = 100; tready_pct = 100; lat_lo = 1; lat_hi = 1; tready_block = 0;
    clear_model();
    @(negedge clk);
    do_reset();

    // ideal memory and sink: back-to-back frames at 0x100, no underflow
    base_addr = 20'h00100; enable = 1'b1;
    run(40);
    check_val("t1_underflow", 32'(underflow), 32'd0);

    // long response latency
    do_reset();
    lat_lo = 20; lat_hi = 20; base_addr = 20'h00100; enable = 1'b1;
    run(150);

    // sink stalled after SOF: requests must stop at full credit
    do_reset();
    lat_lo = 1; lat_hi = 1; tready_block = 55; enable = 1'b1;
    run(40);
    check_val("t3_stall", 32'(mem_req_valid), 32'd0);
    run(80);

    // base_addr moved mid-frame takes effect at the next frame
    do_reset();
    lat_lo = 1; lat_hi = 3; base_addr = 20'h00100; enable = 1'b1;
    n = 0;
    while (fidx != 3 && n < 50) begin step(); n++; end
    check_val("t4_wait", 32'(fidx), 32'd3);
    base_addr = 20'h00200;
    run(60);

    // enable dropped after pixel 3 is requested: frame completes, then idle
    do_reset();
    lat_lo = 1; lat_hi = 1; base_addr = 20'h00100; enable = 1'b1;
    n = 0;
    while (fidx != 4 && n < 50) begin step(); n++; end
    check_val("t5_wait", 32'(fidx), 32'd4);
    enable = 1'b0;
    run(40);
    check_val("t5_idle_tvalid", 32'(out_axis_tvalid), 32'd0);
    check_val("t5_idle_req", 32'(mem_req_valid), 32'd0);
    check_val("t5_drained", 32'(exp_q.size()), 32'd0);

    // randomized traffic, enable toggling, base changes including address wrap
    do_reset();
    base_addr = 20'h00100; enable = 1'b1;
    for (int blk = 0; blk < 40; blk++) begin
      ready_pct  = int'($urandom_range(100, 30));
      tready_pct = int'($urandom_range(100, 30));
      lat_lo     = 1;
      lat_hi     = int'($urandom_range(8, 1));
      enable     = ($urandom_range(9) != 0);
      if ($urandom_range(3) == 0) begin
        rb = AW'($urandom);
        base_addr = ($urandom_range(1) == 0) ? 20'hFFFFC : rb;
      end
      run(50);
    end

    // reset mid-fetch with data buffered, then restart with SOF at the new base
    enable = 1'b1; ready_pct = 100; tready_pct = 100; lat_lo = 1; lat_hi = 2;
    tready_block = 30;
    run(30);
    @(posedge clk);
    #2;
    do_reset();
    lat_lo = 1; lat_hi = 1; tready_block = 0;
    base_addr = 20'h00300; enable = 1'b1;
    run(40);
    check_val("t7_underflow", 32'(underflow), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/svo_fb_stream.md
Name: svo_fb_stream

Overview:
- Framebuffer scan-out source for the HDMI video path. It replaces the test-card generator as the stream feeding the overlay/encoder chain.
- Issues linear pixel reads to a simple request/response memory port and buffers the returned pixels in an internal FIFO.
- Emits an AXI-Stream pixel stream with tuser[0] marking start-of-frame (SOF), in raster order.

Parameters:
- H_RES, 800, active pixels per line
- V_RES, 600, active lines per frame
- BPP, 24, bits per pixel (tdata width)
- ADDR_W, 20, memory word-address width (one word per pixel)
- FIFO_DEPTH, 16, pixel FIFO entries; power of two, at least 4

Ports:
- clk  in  1  pixel clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  scan-out enable; sampled only at frame boundaries
- base_addr  in  ADDR_W  framebuffer start word address; latched at each frame start
- mem_req_valid  out  1  read request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  read word address
- mem_rsp_valid  in  1  read data valid; in request order, any latency of 1 or more cycles, no backpressure
- mem_rsp_data  in  BPP  read data
- out_axis_tvalid  out  1  pixel valid
- out_axis_tready  in  1  downstream ready
- out_axis_tdata  out  BPP  pixel
- out_axis_tuser  out  1  SOF; 1 on pixel (0,0) only
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted downstream
- underflow  out  1  sticky; set when tready=1 and tvalid=0 mid-frame (between SOF and last pixel)

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE; FIFO empty; credit=0; fetch and output counters 0.
  - Reset mid-operation discards FIFO contents and in-flight accounting. The memory subsystem shares this reset, so no stale responses arrive after reset.
- Fetch FSM states:
  - IDLE: mem_req_valid=0. If enable=1, latch base_addr into cur_addr, clear the fetch counter, go to FETCH.
  - FETCH: mem_req_valid=1 while credit < FIFO_DEPTH. A request transfers when valid and ready are both 1; then cur_addr+1 and fetch_cnt+1.
    - On transfer of fetch_cnt = H_RES*V_RES-1 (last pixel): if enable=1, relatch base_addr into cur_addr, clear fetch_cnt, stay in FETCH. Otherwise go to IDLE.
    - Back-to-back frames therefore have no gap.
- Request signal rules:
  - mem_req_addr is stable while mem_req_valid=1 and ready=0.
  - mem_req_valid never drops without a transfer, except under reset.
- Credit counter:
  - credit = FIFO occupancy + requests outstanding.
  - +1 on request transfer; -1 on output handshake; both in the same cycle leaves it unchanged.
  - credit never exceeds FIFO_DEPTH, so the FIFO cannot overflow and mem_rsp_valid is always accepted.
- FIFO:
  - Write on mem_rsp_valid.
  - out_axis_tvalid = FIFO non-empty; tdata and tuser come from the head.
  - First-word fall-through. Latency from a response to tvalid is 1 cycle.
  - Simultaneous write and read when full is impossible because of credit. Simultaneous write and read when empty is a plain write.
- SOF tag:
  - The fetch side stores a SOF bit alongside each pixel, set for fetch_cnt=0, via a small tag FIFO of FIFO_DEPTH entries advanced on request.
  - Alternatively, output-side x/y counters may assert tuser when both are 0.
  - Either implementation is acceptable provided tuser=1 exactly on the first pixel of every frame.
- Output counters:
  - Advance on handshake. x wraps at H_RES-1 to 0, incrementing y; y wraps at V_RES-1 to 0.
  - frame_done pulses in the cycle after the handshake of pixel (H_RES-1, V_RES-1).
- Underflow:
  - Checked only while the output counters are not at (0,0); waiting for the first pixel of a frame is not an error.
  - Cleared only by reset.
- enable deasserted mid-frame: the current frame completes fully and the FIFO drains; then the block sits in IDLE with tvalid=0.
- Address arithmetic: modulo 2^ADDR_W; wrap-around is silent.

Test Plan:
- H_RES=4, V_RES=2, base=0x100, enable=1, mem ready=1, rsp latency 1, tready=1
  -> addresses 0x100..0x107 repeating; tuser=1 on pixels 0 and 8; frame_done after pixel 7; underflow=0.
- Same setup, rsp latency 20, tready=1
  -> at most FIFO_DEPTH requests outstanding; no data lost.
- Same setup, tready low for 50 cycles after SOF
  -> requests stall once credit=16; no overflow; pixels resume in order.
- base_addr changed to 0x200 mid-frame
  -> current frame stays at 0x10x; next frame starts at 0x200 with tuser=1.
- enable dropped at pixel 3
  -> pixels 4..7 still delivered; then mem_req_valid=0 and tvalid=0 remain low.
- Assert reset during FETCH with data in FIFO
  -> all outputs 0 immediately (asynchronous); after release with enable=1, restarts at base with SOF; underflow cleared.
